// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: records GRF writes and stores (up to two per cycle) and streams them out FWFT over valid/ready.
// Define TRACE_DISPLAY_EN to print every popped record and the first overflow (simulation only).
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          grf_we,
  input  logic [4:0]    grf_addr,
  input  logic [31:0]   grf_wdata,
  input  logic [31:0]   grf_pc,
  input  logic [3:0]    mem_byteen,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_kind,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_addr,
  output logic [31:0]   out_data,
  output logic [3:0]    out_byteen,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byteen;
  } rec_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  rec_t          mem [DEPTH];
  rec_t          head, grf_rec, mem_rec;
  logic [AW-1:0] rd_ptr, wr_ptr, mem_slot;
  logic [AW+1:0] free;
  logic          grf_ev, mem_ev, pop, acc_grf, acc_mem;
  logic [1:0]    n_push, n_drop;

  always_comb begin
    grf_ev   = grf_we && (grf_addr != 5'd0);
    mem_ev   = |mem_byteen;
    pop      = out_valid && out_ready;
    // A slot freed by this cycle's pop can be refilled on the same edge.
    free     = (AW+2)'(DEPTH) - (AW+2)'(count) + (AW+2)'(pop);
    acc_grf  = grf_ev && (free != '0);
    acc_mem  = mem_ev && (acc_grf ? (free >= (AW+2)'(2)) : (free != '0));
    n_push   = {1'b0, acc_grf} + {1'b0, acc_mem};
    n_drop   = {1'b0, grf_ev & ~acc_grf} + {1'b0, mem_ev & ~acc_mem};
    mem_slot = acc_grf ? wr_ptr + AW'(1) : wr_ptr;
    grf_rec  = '{kind: 1'b0, pc: grf_pc, addr: {27'b0, grf_addr}, data: grf_wdata, byteen: 4'hF};
    mem_rec  = '{kind: 1'b1, pc: mem_pc, addr: mem_addr & 32'hFFFF_FFFC, data: mem_wdata,
                 byteen: mem_byteen};
  end

  // Control state: pointers, occupancy and drop accounting
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      wr_ptr   <= wr_ptr + AW'(n_push);
      count    <= count + (AW+1)'(n_push) - (AW+1)'(pop);
      if (n_drop != 2'd0) overflow <= 1'b1;
      drop_cnt <= sat_add16(drop_cnt, n_drop);
    end
  end

  // Storage array; GRF and MEM records can land in two consecutive slots on one edge
  always_ff @(posedge clk) begin
    if (acc_grf) mem[wr_ptr]   <= grf_rec;
    if (acc_mem) mem[mem_slot] <= mem_rec;
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (count != '0);
  assign out_kind   = head.kind;
  assign out_pc     = head.pc;
  assign out_addr   = head.addr;
  assign out_data   = head.data;
  assign out_byteen = head.byteen;

`ifdef TRACE_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      if (pop) begin
        if (head.kind) $display("%d@%h: *%h <= %h", $time, head.pc, head.addr, head.data);
        else           $display("%d@%h: $%d <= %h", $time, head.pc, head.addr[4:0], head.data);
      end
      if ((n_drop != 2'd0) && !overflow) $display("TRACE OVERFLOW @%d", $time);
    end
  end
`endif

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: directed vector table, hand-written full/drop/reset sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_commit_trace_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wdata, grf_pc;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_addr, mem_wdata, mem_pc;
  logic        out_valid, out_ready, out_kind;
  logic [31:0] out_pc, out_addr, out_data;
  logic [3:0]  out_byteen;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  commit_trace_fifo #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_addr(grf_addr), .grf_wdata(grf_wdata), .grf_pc(grf_pc),
    .mem_byteen(mem_byteen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_pc(out_pc),
    .out_addr(out_addr), .out_data(out_data), .out_byteen(out_byteen),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } rec_t;

  typedef struct {
    logic        rst_n, rdy, gwe;
    logic [4:0]  ga;
    logic [31:0] gd, gpc;
    logic [3:0]  be;
    logic [31:0] ma, md, mpc;
    logic [4:0]  ecount;
    logic        ekind;
    logic [31:0] epc, eaddr, edata;
    logic [3:0]  ebe;
    logic        eovf;
    logic [15:0] edrop;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  rec_t q[$];
  bit   m_ovf;
  int   m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: spec rules applied to a queue of records for the current inputs.
  task automatic model_edge();
    int  n, free, drops;
    bit  pop, g, m, ag, am;
    rec_t r;
    if (!reset) begin
      q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      n     = q.size();
      pop   = (n != 0) && out_ready;
      free  = DEPTH - n + int'(pop);
      g     = grf_we && (grf_addr != 5'd0);
      m     = (mem_byteen != 4'h0);
      ag    = g && (free >= 1);
      am    = m && (free >= (ag ? 2 : 1));
      drops = int'(g && !ag) + int'(m && !am);
      if (pop) void'(q.pop_front());
      if (ag) begin
        r = '{kind: 1'b0, pc: grf_pc, addr: {27'b0, grf_addr}, data: grf_wdata, be: 4'hF};
        q.push_back(r);
      end
      if (am) begin
        r = '{kind: 1'b1, pc: mem_pc, addr: {mem_addr[31:2], 2'b00}, data: mem_wdata, be: mem_byteen};
        q.push_back(r);
      end
      if (drops > 0) m_ovf = 1'b1;
      m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    rec_t h;
    chk("rnd_count", 32'(count), 32'(q.size()));
    chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
    chk("rnd_drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (q.size() != 0) begin
      h = q[0];
      chk("rnd_kind", 32'(out_kind), 32'(h.kind));
      chk("rnd_pc", out_pc, h.pc);
      chk("rnd_addr", out_addr, h.addr);
      chk("rnd_data", out_data, h.data);
      chk("rnd_byteen", 32'(out_byteen), 32'(h.be));
    end
  endtask

  task automatic idle();
    grf_we = 1'b0; grf_addr = 5'd0; mem_byteen = 4'h0;
  endtask

  task automatic set_grf(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    grf_we = 1'b1; grf_addr = a; grf_wdata = d; grf_pc = pc;
  endtask

  task automatic set_mem(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] pc);
    mem_byteen = be; mem_addr = a; mem_wdata = d; mem_pc = pc;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b0; cycle(); reset = 1'b1;
  endtask

  vec_t vecs[7];

  initial begin
    reset = 1'b1; out_ready = 1'b0;
    grf_wdata = '0; grf_pc = '0; mem_addr = '0; mem_wdata = '0; mem_pc = '0;
    idle();

    vecs[0] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0,
                5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 16'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd5, 32'h1234, 32'h3000, 4'h0, 32'h0, 32'h0, 32'h0,
                5'd1, 1'b0, 32'h3000, 32'h5, 32'h1234, 4'hF, 1'b0, 16'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0,
                5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 16'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 5'd0, 32'hFFFF, 32'h3004, 4'h0, 32'h0, 32'h0, 32'h0,
                5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 16'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 5'd3, 32'hA, 32'h3008, 4'b0011, 32'h106, 32'hBEEF, 32'h300C,
                5'd2, 1'b0, 32'h3008, 32'h3, 32'hA, 4'hF, 1'b0, 16'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0,
                5'd1, 1'b1, 32'h300C, 32'h104, 32'hBEEF, 4'h3, 1'b0, 16'h0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0,
                5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 16'h0};

    for (int i = 0; i < 7; i++) begin
      reset = vecs[i].rst_n; out_ready = vecs[i].rdy;
      grf_we = vecs[i].gwe; grf_addr = vecs[i].ga; grf_wdata = vecs[i].gd; grf_pc = vecs[i].gpc;
      mem_byteen = vecs[i].be; mem_addr = vecs[i].ma; mem_wdata = vecs[i].md; mem_pc = vecs[i].mpc;
      cycle();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecount));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ecount != 5'd0));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].eovf));
      chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].edrop));
      if (vecs[i].ecount != 5'd0) begin
        chk($sformatf("vec%0d_kind", i), 32'(out_kind), 32'(vecs[i].ekind));
        chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].epc);
        chk($sformatf("vec%0d_addr", i), out_addr, vecs[i].eaddr);
        chk($sformatf("vec%0d_data", i), out_data, vecs[i].edata);
        chk($sformatf("vec%0d_byteen", i), 32'(out_byteen), 32'(vecs[i].ebe));
      end
    end
    reset = 1'b1;

    // 17 single events into a stalled FIFO, then drain in order
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_grf(5'((i % 31) + 1), 32'h100 + 32'(i), 32'(i * 4));
      cycle();
    end
    idle();
    chk("fill17_count", 32'(count), 32'd16);
    chk("fill17_overflow", 32'(overflow), 32'd1);
    chk("fill17_drop", 32'(drop_cnt), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_data", i), out_data, 32'h100 + 32'(i));
      chk($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
      cycle();
    end
    chk("drain_empty_count", 32'(count), 32'd0);
    chk("drain_empty_valid", 32'(out_valid), 32'd0);

    // count=15 with GRF+MEM together: GRF kept, MEM dropped
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      set_grf(5'd9, 32'(i), 32'h4000);
      cycle();
    end
    chk("pre15_overflow", 32'(overflow), 32'd0);
    set_grf(5'd10, 32'hCAFE, 32'h4100);
    set_mem(4'hF, 32'h2000, 32'hD00D, 32'h4104);
    cycle();
    idle();
    chk("both15_count", 32'(count), 32'd16);
    chk("both15_drop", 32'(drop_cnt), 32'd1);
    chk("both15_overflow", 32'(overflow), 32'd1);

    // Full with pop plus one event: accepted, no drop
    out_ready = 1'b1;
    set_grf(5'd7, 32'h777, 32'h4200);
    cycle();
    idle();
    chk("fullpop_count", 32'(count), 32'd16);
    chk("fullpop_drop", 32'(drop_cnt), 32'd1);
    chk("fullpop_head", out_data, 32'h1);

    // Saturation of drop_cnt: two drops per cycle while stalled and full
    out_ready = 1'b0;
    set_grf(5'd1, 32'h1, 32'h0);
    set_mem(4'h1, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 32767; i++) cycle();
    chk("sat_drop_reach", 32'(drop_cnt), 32'hFFFF);
    cycle();
    chk("sat_drop_hold", 32'(drop_cnt), 32'hFFFF);
    chk("sat_count", 32'(count), 32'd16);
    idle();

    // Drain to 5 entries, then reset with live inputs
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) cycle();
    chk("pre_reset_count", 32'(count), 32'd5);
    reset = 1'b0;
    set_grf(5'd4, 32'h44, 32'h0);
    set_mem(4'hF, 32'h8, 32'h88, 32'h0);
    cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b1;
    idle();
    cycle();
    chk("post_rst_count", 32'(count), 32'd0);

    // Randomized traffic against the reference model
    begin
      int bias;
      bias = 2;
      for (int i = 0; i < 3000; i++) begin
        if (i % 200 == 0) bias = $urandom_range(0, 4);
        reset      = ($urandom_range(0, 299) != 0);
        out_ready  = ($urandom_range(0, 3) < bias);
        grf_we     = 1'($urandom_range(0, 1));
        grf_addr   = 5'($urandom_range(0, 31));
        grf_wdata  = $urandom;
        grf_pc     = $urandom;
        mem_byteen = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        mem_addr   = $urandom;
        mem_wdata  = $urandom;
        mem_pc     = $urandom;
        cycle();
        check_model();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
